// File: rtl/cook_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cook_sequencer_pkg                                                   |
// | State encodings and BCD digit limits shared by the cook sequencer.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cook_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return (d <= BCD_MAX_ONES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cook_sequencer_bcd_timer4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_timer4                                                           |
// | Four-digit BCD MM:SS register with shift-in, decrement and clear.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_timer4
  import cook_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       dec,
  input  logic       shift_in,
  input  logic [3:0] d_in,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero
);

  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic       w_zero;

  assign w_zero = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_mt <= 4'd0;
      r_mo <= 4'd0;
      r_st <= 4'd0;
      r_so <= 4'd0;
    end else if (dec && !w_zero) begin
      // Seconds tens borrow reloads 5 even if an over-range value was keyed in.
      if (r_so != 4'd0) begin
        r_so <= r_so - 4'd1;
      end else begin
        r_so <= BCD_MAX_ONES;
        if (r_st != 4'd0) begin
          r_st <= r_st - 4'd1;
        end else begin
          r_st <= BCD_MAX_TENS;
          if (r_mo != 4'd0) begin
            r_mo <= r_mo - 4'd1;
          end else begin
            r_mo <= BCD_MAX_ONES;
            r_mt <= r_mt - 4'd1;
          end
        end
      end
    end else if (shift_in) begin
      r_mt <= r_mo;
      r_mo <= r_st;
      r_st <= r_so;
      r_so <= d_in;
    end
  end

  assign min_tens = r_mt;
  assign min_ones = r_mo;
  assign sec_tens = r_st;
  assign sec_ones = r_so;
  assign zero     = w_zero;

endmodule
`default_nettype wire

// File: rtl/cook_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cook_sequencer                                                       |
// | Microwave cook-cycle controller: keypad capture, countdown, alarm.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cook_sequencer
  import cook_sequencer_pkg::*;
#(
  parameter int ALARM_SECS = 3
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       done_alarm,
  output logic [2:0] state
);

  localparam int CNT_W = (ALARM_SECS > 2) ? $clog2(ALARM_SECS) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_alarm_cnt;
  logic               r_loadn_d1, r_loadn_d2;
  logic               r_startn_d1, r_startn_d2;
  logic               r_stopn_d1, r_stopn_d2;
  logic               r_pgt_d1, r_pgt_d2;
  logic [3:0]         r_d_d1;

  logic w_key, w_start, w_stop, w_tick, w_abort;
  logic w_zero, w_one, w_can_cook;
  logic w_shift, w_dec, w_clr;

  // Two-stage sampling: the edge is seen one cycle after capture.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_loadn_d1  <= 1'b1;
      r_loadn_d2  <= 1'b1;
      r_startn_d1 <= 1'b1;
      r_startn_d2 <= 1'b1;
      r_stopn_d1  <= 1'b1;
      r_stopn_d2  <= 1'b1;
      r_pgt_d1    <= 1'b0;
      r_pgt_d2    <= 1'b0;
      r_d_d1      <= 4'd0;
    end else begin
      r_loadn_d1  <= loadn;
      r_loadn_d2  <= r_loadn_d1;
      r_startn_d1 <= startn;
      r_startn_d2 <= r_startn_d1;
      r_stopn_d1  <= stopn;
      r_stopn_d2  <= r_stopn_d1;
      r_pgt_d1    <= pgt_1Hz;
      r_pgt_d2    <= r_pgt_d1;
      r_d_d1      <= D;
    end
  end

  assign w_key   = r_loadn_d2 & ~r_loadn_d1 & bcd_digit_ok(r_d_d1);
  assign w_start = r_startn_d2 & ~r_startn_d1;
  assign w_stop  = r_stopn_d2 & ~r_stopn_d1;
  assign w_tick  = ~r_pgt_d2 & r_pgt_d1;
  assign w_abort = w_stop | ~door_closed;

  assign w_one      = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_ones == 4'd1);
  assign w_can_cook = w_start & door_closed & ~w_zero;

  always_comb begin
    w_shift = 1'b0;
    w_dec   = 1'b0;
    w_clr   = 1'b0;
    case (r_state)
      ST_IDLE, ST_ENTRY: begin
        if (w_stop)               w_clr   = 1'b1;
        else if (!w_can_cook)     w_shift = w_key;
      end
      ST_COOK:  w_dec = ~w_abort & w_tick;
      ST_PAUSE: w_clr = w_stop;
      default: ;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_alarm_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ENTRY: begin
          if (w_stop)          r_state <= ST_IDLE;
          else if (w_can_cook) r_state <= ST_COOK;
          else if (w_key)      r_state <= ST_ENTRY;
        end
        ST_COOK: begin
          if (w_abort) begin
            r_state <= ST_PAUSE;
          end else if (w_tick && w_one) begin
            r_state     <= ST_DONE;
            r_alarm_cnt <= '0;
          end
        end
        ST_PAUSE: begin
          if (w_stop)                       r_state <= ST_IDLE;
          else if (w_start && door_closed)  r_state <= ST_COOK;
        end
        ST_DONE: begin
          if (w_abort) begin
            r_state     <= ST_IDLE;
            r_alarm_cnt <= '0;
          end else if (w_tick) begin
            if (r_alarm_cnt == CNT_W'(ALARM_SECS - 1)) begin
              r_state     <= ST_IDLE;
              r_alarm_cnt <= '0;
            end else begin
              r_alarm_cnt <= r_alarm_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  bcd_timer4 u_timer (
    .clk      (clk100),
    .rst      (rst),
    .clr      (w_clr),
    .dec      (w_dec),
    .shift_in (w_shift),
    .d_in     (r_d_d1),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .zero     (w_zero)
  );

  assign zero       = w_zero;
  assign state      = r_state;
  assign enablen    = (r_state != ST_COOK);
  assign mag_on     = (r_state == ST_COOK);
  assign done_alarm = (r_state == ST_DONE);

endmodule
`default_nettype wire
